// File: rtl/input_debouncer.sv
// Synchronising debouncer: a SYNC_STAGES flop chain followed by a two-state qualifier
// that accepts a new level only after STABLE_CYCLES consecutive differing samples.
// Optional one-cycle rise/fall pulses are built when DEBOUNCE_EDGE_PULSE_EN is defined.
module input_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic d_out,
    output logic rise,
    output logic fall,
    output logic busy
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(STABLE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_count;
    logic [CW-1:0]          w_countNext;
    logic                   r_dOut;
    logic                   w_dOutNext;
    logic                   r_busy;
    logic                   w_syncQ;
    logic                   w_differ;
    logic                   w_atLimit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
        end
    end

    assign w_syncQ   = r_sync[SYNC_STAGES-1];
    assign w_differ  = (w_syncQ != r_dOut);
    // The current edge is the STABLE_CYCLES-th consecutive differing sample.
    assign w_atLimit = (r_count >= LAST_COUNT);

    always_comb begin
        w_stateNext = r_state;
        w_countNext = r_count;
        w_dOutNext  = r_dOut;
        case (r_state)
            ST_STABLE: begin
                w_countNext = '0;
                if (w_differ) begin
                    if (w_atLimit) begin
                        w_dOutNext = w_syncQ;
                    end else begin
                        w_stateNext = ST_PENDING;
                        w_countNext = r_count + CW'(1);
                    end
                end
            end
            ST_PENDING: begin
                if (!w_differ) begin
                    w_stateNext = ST_STABLE;
                    w_countNext = '0;
                end else if (w_atLimit) begin
                    w_stateNext = ST_STABLE;
                    w_countNext = '0;
                    w_dOutNext  = w_syncQ;
                end else begin
                    w_countNext = r_count + CW'(1);
                end
            end
            default: begin
                w_stateNext = ST_STABLE;
                w_countNext = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_STABLE;
            r_count <= '0;
            r_dOut  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_count <= w_countNext;
            r_dOut  <= w_dOutNext;
            r_busy  <= (w_stateNext == ST_PENDING);
        end
    end

    assign d_out = r_dOut;
    assign busy  = r_busy;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic r_rise;
    logic r_fall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_dOutNext & ~r_dOut;
            r_fall <= ~w_dOutNext & r_dOut;
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Input conditioning stage that sits directly upstream of the team's D flip-flop register stage. It takes a raw asynchronous level (push-button, switch, external line), synchronises it into the `clk` domain, and rejects bounce or glitches shorter than a programmable stability window. It drives a clean registered level, `d_out`, that feeds the flip-flop's `D` input. Optionally it also produces one-cycle rise and fall pulses.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: number of synchroniser flops; legal range ≥ 2.
- `STABLE_CYCLES`, default 16: consecutive synchronised cycles a new level must hold before it is accepted; legal range ≥ 1. The internal counter width is `$clog2(STABLE_CYCLES+1)`.

Ports:
- `clk`  input  1  sole clock; all logic updates on the rising edge.
- `reset`  input  1  synchronous, active-low reset: sampled on the rising edge of `clk`, asserted when 0.
- `din`  input  1  raw asynchronous input level.
- `d_out`  output  1  debounced registered level, to the downstream flip-flop's `D`.
- `rise`  output  1  one-cycle pulse when `d_out` goes 0→1.
- `fall`  output  1  one-cycle pulse when `d_out` goes 1→0.
- `busy`  output  1  high while a candidate level change is being qualified.

## Operation
- **Synchroniser:** a shift chain of `SYNC_STAGES` flops on `din`. `sync_q` is the last stage; no other logic reads `din`.
- **State machine (two states):**
  - STABLE: `sync_q == d_out`; counter held at 0; `busy` = 0.
  - PENDING: entered on the first edge where `sync_q != d_out`. The counter increments on every edge on which `sync_q != d_out` persists.
  - PENDING → STABLE with accept: on the edge where the count reaches `STABLE_CYCLES` with `sync_q` still differing. `d_out` ← `sync_q` and the counter clears.
  - PENDING → STABLE with reject: on any edge where `sync_q == d_out` (glitch). The counter clears, `d_out` is unchanged, and no pulse is issued.
- **Pulses:** `rise`/`fall` are registered and assert on the same edge that `d_out` changes, for exactly one cycle.
- **Counter:** saturating, never wraps. Its maximum is `STABLE_CYCLES`.
- **`busy`:** registered; equals (state == PENDING).
- **Reset:** on any edge with `reset` = 0:
  - all synchroniser flops, `d_out`, `rise`, `fall`, `busy` and the counter go to 0, and the state goes to STABLE.
  - Reset overrides every other event, including an accept on the same edge. A reset during PENDING discards the candidate.
- **After reset release with `din` = 1:** the block qualifies the 0→1 change normally, including a `rise` pulse.

## Timing
- Reset value of every output is 0.
- **Latency:** count the first rising edge that samples a new stable `din` level as edge 1. `d_out` changes on edge `SYNC_STAGES + STABLE_CYCLES` (defaults: edge 18).
- **Glitch rejection:** any `sync_q` excursion lasting fewer than `STABLE_CYCLES` consecutive cycles produces no change on `d_out`, `rise` or `fall`.
- **Pulse spacing:** `rise` and `fall` are never high together. Consecutive pulses are at least `STABLE_CYCLES` cycles apart.
- **`busy` timing:** rises one edge after `sync_q` first differs from `d_out`. It falls on the accept or reject edge.
- **Edge case `STABLE_CYCLES` = 1:** a single differing `sync_q` cycle is accepted. Latency is `SYNC_STAGES + 1`.

## Configuration
- Macro: `DEBOUNCE_EDGE_PULSE_EN`.
- **Defined:** the `rise`/`fall` pulse registers are generated as described above.
- **Undefined:**
  - The pulse registers are not built, and `rise` and `fall` are tied to constant 0.
  - The ports remain present, so instantiations are unchanged.
  - `d_out`, `busy` and latency are identical to the defined case.

## Test plan
- **Clean press** (defaults): reset low 3 cycles, then release; `din` 0→1 and held. Required: `busy` = 1 from edge 3; `d_out` = 1 and `rise` = 1 on edge 18 only; `fall` stays 0.
- **Glitch reject:** `din` high for 10 cycles, then low. Required: `busy` pulses high and then returns to 0; `d_out`, `rise` and `fall` stay 0 throughout.
- **Bounce train:** `din` toggles every 3 cycles for 5 toggles, then holds 1. Required: exactly one `rise` pulse, 18 edges after the final transition is first sampled; `d_out` = 1 afterwards.
- **Release:** from `d_out` = 1, `din` → 0 and held. Required: `d_out` = 0 and `fall` = 1 for one cycle on edge 18; `rise` = 0.
- **Reset mid-PENDING:** `din` → 1, then `reset` = 0 on edge 10. Required: on that edge all outputs are 0 and `busy` = 0. After release with `din` still 1, `d_out` rises 18 edges later with a `rise` pulse.
- **Build variants:**
  - `STABLE_CYCLES` = 1, `SYNC_STAGES` = 2: `din` 0→1 gives `d_out` = 1 on edge 3.
  - Build without `DEBOUNCE_EDGE_PULSE_EN`: `rise` and `fall` stay 0 across all scenarios above.
